param_adder_pipe: RTL and testbench
===================================

Name: param_adder_pipe

Overview:
- Parametrised successor to the team's 8-bit registered adder.
- Three-stage pipelined unsigned add/subtract with optional offset and saturation, plus valid/ready handshake with backpressure.
- Control/status registers sit on the existing Des_* style register port.
- Sits between an operand producer and a result consumer; configured by the host over the register port.

Parameters:
- WIDTH, 8, operand/result/register data width (≥4).
- ADDR_W, 3, register address width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  WIDTH  operand A, unsigned
- in_b  in  WIDTH  operand B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_carry  out  1  result out of range (overflow or underflow)
- des_req_valid  in  1  register access request
- des_wr_rd  in  1  1 = write, 0 = read
- des_address  in  ADDR_W  register address
- des_value  in  WIDTH  write data
- des_rd_value  out  WIDTH  read data, combinational

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No asynchronous paths.
- Reset: all pipeline valids, out_valid, out_sum, out_carry and all registers go to 0 at the edge where rst=1. Reset mid-operation discards in-flight data; out_valid=0 the following cycle.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift together only when adv=1 (global stall); otherwise every stage holds its data.
- S1 (capture) on in_valid && in_ready: registers a, b, control[2:0] and offset. Config written later never affects an operation already accepted.
- S2: v = a + b (ctrl.sub=0) or a - b (ctrl.sub=1), held as WIDTH+2-bit signed.
- S3: v2 = v + (ctrl.off_en ? offset : 0).
  - hi = v2 > 2^WIDTH-1; lo = v2 < 0.
  - out_carry = hi | lo.
  - out_sum = ctrl.sat ? (hi ? all ones : lo ? 0 : v2[WIDTH-1:0]) : v2[WIDTH-1:0].
- Latency: accept at edge N → out_valid=1 after edge N+3 when there is no stall. Throughput 1 result/cycle. Order is preserved. out_sum/out_carry hold stable while out_valid && !out_ready.
- Bubbles (invalid slots) advance like data; out_valid is the S3 valid.
- Registers (write on des_req_valid && des_wr_rd; read data = selected value when des_req_valid && !des_wr_rd, else 0):
  - 0 CONTROL RW: bit0 off_en, bit1 sub, bit2 sat, other bits read 0.
  - 1 OFFSET RW.
  - 2 GENERAL RW.
  - 3 STATUS: bit0 sticky overflow, set when a result with out_carry=1 completes its handshake; writing 1 to bit0 clears it. Simultaneous set and clear → set wins.
  - 4 RESULT_COUNT RO: counts out_valid && out_ready handshakes, wraps at 2^WIDTH. Any write clears it; a write coincident with a handshake → 0 (write wins).
  - Addresses 5-7: reads return 0, writes are ignored.
- Reads are combinational from current register state: a read in the same cycle as a write returns the old value.

Decomposition:
- Shared package param_adder_pkg holds:
  - register address constants (ADDR_CONTROL..ADDR_RESULT_COUNT)
  - control bit indices (CTRL_OFF_EN=0, CTRL_SUB=1, CTRL_SAT=2)
  - the STATUS overflow bit index
- One sub-module, adder_csr: register file, read mux, sticky status and result counter. It exports control/offset and takes the handshake/overflow events.
- The pipeline stays in param_adder_pipe.

Test Plan (WIDTH=8):
- CONTROL=0; a=0x12, b=0x34, out_ready=1 → out_sum=0x46, out_carry=0, exactly 3 cycles after accept; RESULT_COUNT reads 1.
- a=0xF0, b=0x20 add, sat=0 → out_sum=0x10, out_carry=1, STATUS=0x01; with sat=1 → 0xFF, carry 1; write 0x01 to addr 3 → STATUS reads 0x00.
- Subtract, sat=0: a=0x10, b=0x20 → 0xF0, carry 1; sat=1 → 0x00, carry 1. off_en=1, OFFSET=0x05, a=0x10, b=0x0C → 0x09, carry 0.
- Backpressure: stream 5 ops back-to-back while out_ready is held low for 4 cycles → in_ready=0 while stalled, outputs stable, all 5 results delivered in order, RESULT_COUNT=5.
- In-flight config: accept a=0x01, b=0x01 with off_en=0, then next cycle write CONTROL=0x01, OFFSET=0x10 → first result 0x02; the next op accepted after the write (a=0x01, b=0x01) → 0x12.
- Assert rst for 1 cycle with the pipeline full and all registers nonzero → out_valid=0 on the next cycle, no further results emerge, reads of addr 0-4 return 0x00.

Source files
------------

// File: rtl/param_adder_pkg.sv
// param_adder_pkg: shared register map, control bit indices and status bit index for param_adder_pipe
package param_adder_pkg;
  localparam int ADDR_CONTROL = 0;
  localparam int ADDR_OFFSET = 1;
  localparam int ADDR_GENERAL = 2;
  localparam int ADDR_STATUS = 3;
  localparam int ADDR_RESULT_COUNT = 4;
  localparam int CTRL_OFF_EN = 0;
  localparam int CTRL_SUB = 1;
  localparam int CTRL_SAT = 2;
  localparam int CTRL_W = 3;
  localparam int STATUS_OVF = 0;
  typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/param_adder_pipe_if.sv
// param_adder_pipe_if: operand/result valid-ready streams plus Des_* register port
// master = producer/consumer/host side, slave = param_adder_pipe side
interface param_adder_pipe_if #(parameter int WIDTH = 8, parameter int ADDR_W = 3);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_sum;
  logic out_carry;
  logic des_req_valid;
  logic des_wr_rd;
  logic [ADDR_W-1:0] des_address;
  logic [WIDTH-1:0] des_value;
  logic [WIDTH-1:0] des_rd_value;
  modport master (
    output in_valid, in_a, in_b, out_ready, des_req_valid, des_wr_rd, des_address, des_value,
    input in_ready, out_valid, out_sum, out_carry, des_rd_value
  );
  modport slave (
    input in_valid, in_a, in_b, out_ready, des_req_valid, des_wr_rd, des_address, des_value,
    output in_ready, out_valid, out_sum, out_carry, des_rd_value
  );
endinterface

// File: rtl/adder_csr.sv
// adder_csr: control/offset/general registers, sticky overflow status, result counter, read mux
// i_req/i_wr/i_addr/i_wdata: register access; i_hs/i_ovf: result handshake and overflowing handshake
// o_ctrl/o_offset: live config to the pipeline; o_rd_value: combinational read data
module adder_csr
  import param_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_hs,
  input  logic              i_ovf,
  output ctrl_t             o_ctrl,
  output logic [WIDTH-1:0]  o_offset,
  output logic [WIDTH-1:0]  o_rd_value
);
  ctrl_t r_ctrl;
  logic [WIDTH-1:0] r_offset, r_general, r_count;
  logic r_ovf;
  logic w_we, w_rd, w_ctl, w_off, w_gen, w_sts, w_cnt;
  assign w_we = i_req && i_wr;
  assign w_rd = i_req && !i_wr;
  assign w_ctl = i_addr == ADDR_W'(ADDR_CONTROL);
  assign w_off = i_addr == ADDR_W'(ADDR_OFFSET);
  assign w_gen = i_addr == ADDR_W'(ADDR_GENERAL);
  assign w_sts = i_addr == ADDR_W'(ADDR_STATUS);
  assign w_cnt = i_addr == ADDR_W'(ADDR_RESULT_COUNT);
  assign o_ctrl = r_ctrl;
  assign o_offset = r_offset;
  assign o_rd_value = !w_rd ? '0 :
                      w_ctl ? WIDTH'(r_ctrl) :
                      w_off ? r_offset :
                      w_gen ? r_general :
                      w_sts ? WIDTH'(r_ovf) << STATUS_OVF :
                      w_cnt ? r_count : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_offset <= '0;
      r_general <= '0;
      r_ovf <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_we && w_ctl) r_ctrl <= i_wdata[CTRL_W-1:0];
      if (w_we && w_off) r_offset <= i_wdata;
      if (w_we && w_gen) r_general <= i_wdata;
      // a new overflow beats a simultaneous write-1-to-clear
      r_ovf <= i_ovf || (r_ovf && !(w_we && w_sts && i_wdata[STATUS_OVF]));
      // any write clears, and wins over a coincident handshake
      r_count <= (w_we && w_cnt) ? '0 : r_count + WIDTH'(i_hs);
    end
  end
endmodule

// File: rtl/param_adder_pipe.sv
// param_adder_pipe: pipelined unsigned add/subtract with optional offset and saturation
// clk/rst: clock, synchronous active-high reset; bus: operand/result streams and register port
module param_adder_pipe
  import param_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 3
) (
  input logic clk,
  input logic rst,
  param_adder_pipe_if.slave bus
);
  ctrl_t w_ctrl, r1_ctrl;
  logic [WIDTH-1:0] w_offset, r1_a, r1_b, r1_off, r2_off, r_sum;
  logic [WIDTH+1:0] r2_sum;
  logic [WIDTH+2:0] r3_sum;
  logic r1_v, r2_v, r3_v, r_out_v, r2_sat, r3_sat, r_carry;
  logic w_adv, w_hs, w_hi, w_lo;
  // every stage moves together; a stalled output freezes the whole pipe
  assign w_adv = !r_out_v || bus.out_ready;
  assign w_hs = r_out_v && bus.out_ready;
  assign bus.in_ready = w_adv;
  assign bus.out_valid = r_out_v;
  assign bus.out_sum = r_sum;
  assign bus.out_carry = r_carry;
  // r3_sum is two's complement one bit wider than r2_sum so offset on top of a full add cannot wrap
  assign w_lo = r3_sum[WIDTH+2];
  assign w_hi = !w_lo && |r3_sum[WIDTH+1:WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v <= 1'b0;
      r1_a <= '0;
      r1_b <= '0;
      r1_ctrl <= '0;
      r1_off <= '0;
      r2_v <= 1'b0;
      r2_sum <= '0;
      r2_off <= '0;
      r2_sat <= 1'b0;
      r3_v <= 1'b0;
      r3_sum <= '0;
      r3_sat <= 1'b0;
      r_out_v <= 1'b0;
      r_sum <= '0;
      r_carry <= 1'b0;
    end else if (w_adv) begin
      r1_v <= bus.in_valid;
      r1_a <= bus.in_a;
      r1_b <= bus.in_b;
      r1_ctrl <= w_ctrl;
      r1_off <= w_offset;
      r2_v <= r1_v;
      r2_sum <= r1_ctrl[CTRL_SUB] ? {2'b0, r1_a} - {2'b0, r1_b} : {2'b0, r1_a} + {2'b0, r1_b};
      r2_off <= r1_ctrl[CTRL_OFF_EN] ? r1_off : '0;
      r2_sat <= r1_ctrl[CTRL_SAT];
      r3_v <= r2_v;
      r3_sum <= {r2_sum[WIDTH+1], r2_sum} + {3'b0, r2_off};
      r3_sat <= r2_sat;
      r_out_v <= r3_v;
      r_sum <= r3_sat ? (w_hi ? '1 : w_lo ? '0 : r3_sum[WIDTH-1:0]) : r3_sum[WIDTH-1:0];
      r_carry <= w_hi || w_lo;
    end
  end
  adder_csr #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_csr (
    .clk(clk),
    .rst(rst),
    .i_req(bus.des_req_valid),
    .i_wr(bus.des_wr_rd),
    .i_addr(bus.des_address),
    .i_wdata(bus.des_value),
    .i_hs(w_hs),
    .i_ovf(w_hs && r_carry),
    .o_ctrl(w_ctrl),
    .o_offset(w_offset),
    .o_rd_value(bus.des_rd_value)
  );
endmodule

// File: tb/tb_param_adder_pipe.sv
// tb_param_adder_pipe: directed self-checking bench for param_adder_pipe at WIDTH=8
module tb_param_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  param_adder_pipe_if #(.WIDTH(8), .ADDR_W(3)) bus ();
  param_adder_pipe #(.WIDTH(8), .ADDR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic reg_write(input logic [2:0] addr, input logic [7:0] val);
    @(negedge clk);
    bus.des_req_valid = 1'b1;
    bus.des_wr_rd = 1'b1;
    bus.des_address = addr;
    bus.des_value = val;
    @(posedge clk);
    #1;
    bus.des_req_valid = 1'b0;
    bus.des_wr_rd = 1'b0;
  endtask
  task automatic reg_read(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    @(negedge clk);
    bus.des_req_valid = 1'b1;
    bus.des_wr_rd = 1'b0;
    bus.des_address = addr;
    #1;
    check(tag, bus.des_rd_value, exp);
    bus.des_req_valid = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_early_valid"}, bus.out_valid, 0);
    end
    @(negedge clk);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_sum"}, bus.out_sum, es);
    check({tag, "_carry"}, bus.out_carry, ec);
    exp_cnt++;
  endtask
  task automatic wait_result(input string tag, input logic [7:0] es, input logic ec);
    logic seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check({tag, "_valid"}, seen, 1);
    check({tag, "_sum"}, bus.out_sum, es);
    check({tag, "_carry"}, bus.out_carry, ec);
    exp_cnt++;
  endtask
  initial begin
    logic [7:0] exp_bp [5];
    logic [7:0] held;
    logic held_v, acc;
    int sent, got, stalls, seen;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    bus.des_req_valid = 1'b0;
    bus.des_wr_rd = 1'b0;
    bus.des_address = '0;
    bus.des_value = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_carry", bus.out_carry, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("idle_rd_zero", bus.des_rd_value, 0);
    for (int i = 0; i < 5; i++) reg_read("rst_reg", 3'(i), 8'h00);
    reg_write(0, 8'h00);
    run_op("add", 8'h12, 8'h34, 8'h46, 1'b0);
    reg_read("cnt_one", 4, 8'h01);
    run_op("add_ovf", 8'hF0, 8'h20, 8'h10, 1'b1);
    reg_read("status_set", 3, 8'h01);
    reg_write(0, 8'h04);
    run_op("add_sat", 8'hF0, 8'h20, 8'hFF, 1'b1);
    reg_write(3, 8'h01);
    reg_read("status_clr", 3, 8'h00);
    reg_write(0, 8'h02);
    run_op("sub", 8'h10, 8'h20, 8'hF0, 1'b1);
    reg_write(0, 8'h06);
    run_op("sub_sat", 8'h10, 8'h20, 8'h00, 1'b1);
    run_op("sub_zero", 8'h20, 8'h20, 8'h00, 1'b0);
    reg_write(0, 8'h03);
    reg_write(1, 8'h05);
    run_op("sub_off", 8'h10, 8'h0C, 8'h09, 1'b0);
    reg_write(0, 8'h05);
    run_op("sat_edge", 8'hF0, 8'h0A, 8'hFF, 1'b0);
    reg_write(1, 8'hFF);
    run_op("off_big_sat", 8'hFF, 8'hFF, 8'hFF, 1'b1);
    reg_write(0, 8'h01);
    run_op("off_big", 8'hFF, 8'hFF, 8'hFD, 1'b1);
    reg_read("cnt_many", 4, 8'(exp_cnt));
    reg_read("ctrl_rb", 0, 8'h01);
    reg_write(4, 8'h77);
    reg_read("cnt_clr", 4, 8'h00);
    reg_write(5, 8'hFF);
    reg_read("addr5", 5, 8'h00);
    reg_write(0, 8'h00);
    for (int i = 0; i < 5; i++) exp_bp[i] = 8'(17 * (i + 1));
    sent = 0;
    got = 0;
    stalls = 0;
    held_v = 1'b0;
    acc = 1'b0;
    held = '0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (acc) sent++;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        if (held_v) check("bp_hold_sum", bus.out_sum, held);
        held = bus.out_sum;
        held_v = 1'b1;
        if (stalls == 4) bus.out_ready = 1'b1;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) check("bp_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        check("bp_order", bus.out_sum, exp_bp[got]);
        got++;
      end
      bus.in_valid = sent < 5;
      bus.in_a = 8'(sent + 1);
      bus.in_b = 8'(16 * (sent + 1));
      acc = bus.in_valid && bus.in_ready;
    end
    bus.in_valid = 1'b0;
    check("bp_stalls", stalls, 4);
    check("bp_delivered", got, 5);
    reg_read("bp_cnt", 4, 8'h05);
    exp_cnt = 5;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 8'h01;
    bus.in_b = 8'h01;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    reg_write(0, 8'h01);
    reg_write(1, 8'h10);
    wait_result("cfg_old", 8'h02, 1'b0);
    run_op("cfg_new", 8'h01, 8'h01, 8'h12, 1'b0);
    reg_write(2, 8'hA5);
    reg_read("general_rb", 2, 8'hA5);
    reg_read("status_pre", 3, 8'h01);
    reg_read("cnt_pre", 4, 8'(exp_cnt));
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a = 8'(i + 1);
      bus.in_b = 8'(i + 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("full_before_rst", bus.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("rst_mid_valid", bus.out_valid, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(bus.out_valid);
    end
    check("rst_drain", seen, 0);
    for (int i = 0; i < 5; i++) reg_read("rst2_reg", 3'(i), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
